pic_banked_regfile: RTL and testbench

//  Next-generation PIC16C5x-class register file. Adds banked GPRs, a TMR0 counter, latched I/O ports and a PCL write strobe.

---
 rtl/rf_pkg.sv | 31 +++
 rtl/rf_tmr0.sv | 66 ++++++
 rtl/pic_banked_regfile.sv | 144 ++++++++++++++
 tb/tb_pic_banked_regfile.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the banked PIC register file: file map, write commands
// and STATUS layout.
package rf_pkg;

  localparam logic [4:0] ADDR_INDF   = 5'h00;
  localparam logic [4:0] ADDR_TMR0   = 5'h01;
  localparam logic [4:0] ADDR_PCL    = 5'h02;
  localparam logic [4:0] ADDR_STATUS = 5'h03;
  localparam logic [4:0] ADDR_FSR    = 5'h04;
  localparam logic [4:0] ADDR_PORTA  = 5'h05;
  localparam logic [4:0] ADDR_PORTB  = 5'h06;
  localparam logic [4:0] ADDR_PORTC  = 5'h07;
  localparam logic [4:0] ADDR_GPR_LO = 5'h08;

  typedef enum logic [2:0] {
    WCMD_IDLE       = 3'b000,
    WCMD_STATUS     = 3'b001,
    WCMD_FILE       = 3'b010,
    WCMD_FILE_FLAGS = 3'b011,
    WCMD_FSR        = 3'b100
  } wcmd_e;

  localparam int unsigned STATUS_C  = 0;
  localparam int unsigned STATUS_DC = 1;
  localparam int unsigned STATUS_Z  = 2;
  localparam int unsigned STATUS_PD = 3;
  localparam int unsigned STATUS_TO = 4;

  localparam logic [7:0] STATUS_RST = 8'h18;

endpackage

// File: rtl/rf_tmr0.sv
// TMR0 counter with post-write tick inhibit and overflow pulse.
// Optional prescaler enabled by defining RF_TMR0_PRESCALER_EN.
module rf_tmr0 #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            option,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  ovf
);

  logic [DATA_WIDTH-1:0] r_value;
  logic [1:0]            r_inhibit;
  logic                  r_ovf;
  logic                  w_tick;

`ifdef RF_TMR0_PRESCALER_EN
  logic [7:0] r_presc;
  logic [7:0] w_mask;

  // Free-running prescaler; a tick fires when the low PS+1 bits are all ones,
  // so a ratio change takes effect at the next terminal count.
  always_comb begin
    w_mask = 8'((9'd2 << option[2:0]) - 9'd1);
    w_tick = option[3] || ((r_presc & w_mask) == w_mask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_presc <= '0;
    else if (wr) r_presc <= '0;
    else         r_presc <= r_presc + 8'd1;
  end
`else
  logic w_unused_option;
  assign w_unused_option = ^option;
  assign w_tick          = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value   <= '0;
      r_inhibit <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= 1'b0;
      if (wr) begin
        r_value   <= wr_data;
        r_inhibit <= 2'd2;
      end else if (w_tick) begin
        if (r_inhibit != 2'd0) begin
          r_inhibit <= r_inhibit - 2'd1;
        end else begin
          r_value <= r_value + 1'b1;
          r_ovf   <= &r_value;
        end
      end
    end
  end

  assign value = r_value;
  assign ovf   = r_ovf;

endmodule

// File: rtl/pic_banked_regfile.sv
// Banked PIC16C5x-class register file: special registers, port latches,
// common and FSR-banked GPRs. TMR0 prescaler via RF_TMR0_PRESCALER_EN.
module pic_banked_regfile
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PC_WIDTH   = 11,
  parameter int unsigned NUM_BANKS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            write_cmd,
  input  logic [4:0]            file_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] status_in,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [3:0]            option_in,
  input  logic [DATA_WIDTH-1:0] port_a_in,
  input  logic [DATA_WIDTH-1:0] port_b_in,
  input  logic [DATA_WIDTH-1:0] port_c_in,
  output logic [DATA_WIDTH-1:0] port_a_out,
  output logic [DATA_WIDTH-1:0] port_b_out,
  output logic [DATA_WIDTH-1:0] port_c_out,
  output logic [DATA_WIDTH-1:0] regfile_out,
  output logic [DATA_WIDTH-1:0] status_out,
  output logic [DATA_WIDTH-1:0] fsr_out,
  output logic [DATA_WIDTH-1:0] tmr0_out,
  output logic                  tmr0_ovf,
  output logic                  pcl_wr
);

  localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned GPR_N  = 8 + 16 * NUM_BANKS;
  localparam int unsigned IDX_W  = $clog2(GPR_N);

  logic [DATA_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0] r_fsr;
  logic [DATA_WIDTH-1:0] r_port_a;
  logic [DATA_WIDTH-1:0] r_port_b;
  logic [DATA_WIDTH-1:0] r_port_c;
  logic [DATA_WIDTH-1:0] r_gpr [GPR_N];

  wcmd_e                 w_cmd;
  logic [4:0]            w_ea;
  logic [BANK_W-1:0]     w_bank;
  logic [IDX_W-1:0]      w_gpr_idx;
  logic                  w_is_gpr;
  logic                  w_file_wr;
  logic                  w_flags_wr;
  logic                  w_tmr_wr;
  logic [DATA_WIDTH-1:0] w_tmr0;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_status_nxt;
  logic                  w_unused_in;

  assign w_unused_in = ^{status_in[DATA_WIDTH-1:3], pc_in[PC_WIDTH-1:8]};

  assign w_cmd      = wcmd_e'(write_cmd);
  assign w_ea       = (file_addr == ADDR_INDF) ? r_fsr[4:0] : file_addr;
  assign w_is_gpr   = (w_ea >= ADDR_GPR_LO);
  assign w_file_wr  = (w_cmd == WCMD_FILE) || (w_cmd == WCMD_FILE_FLAGS);
  assign w_flags_wr = (w_cmd == WCMD_FILE_FLAGS) || (w_cmd == WCMD_STATUS);
  assign w_tmr_wr   = w_file_wr && (w_ea == ADDR_TMR0);
  assign pcl_wr     = w_file_wr && (w_ea == ADDR_PCL);

  // Array layout: 0..7 common GPRs (0x08-0x0F), then 16 entries per bank.
  always_comb begin
    w_bank = '0;
    if (NUM_BANKS > 1) w_bank = r_fsr[5 +: BANK_W];
    if (w_ea[4]) w_gpr_idx = IDX_W'({w_bank, w_ea[3:0]}) + IDX_W'(8);
    else         w_gpr_idx = IDX_W'(w_ea[2:0]);
  end

  rf_tmr0 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tmr0 (
    .clk     (clk),
    .rst     (rst),
    .wr      (w_tmr_wr),
    .wr_data (write_data),
    .option  (option_in),
    .value   (w_tmr0),
    .ovf     (tmr0_ovf)
  );

  always_comb begin
    w_rd = '0;
    case (w_ea)
      ADDR_INDF:   w_rd = '0;
      ADDR_TMR0:   w_rd = w_tmr0;
      ADDR_PCL:    w_rd[7:0] = pc_in[7:0];
      ADDR_STATUS: w_rd = r_status;
      ADDR_FSR:    w_rd = r_fsr;
      ADDR_PORTA:  w_rd = port_a_in;
      ADDR_PORTB:  w_rd = port_b_in;
      ADDR_PORTC:  w_rd = port_c_in;
      default:     w_rd = r_gpr[w_gpr_idx];
    endcase
  end

  // TO/PD (bits 4:3) are never written; flags from status_in override data.
  always_comb begin
    w_status_nxt = r_status;
    if (w_file_wr && (w_ea == ADDR_STATUS)) begin
      w_status_nxt[DATA_WIDTH-1:5] = write_data[DATA_WIDTH-1:5];
      w_status_nxt[2:0]            = write_data[2:0];
    end
    if (w_flags_wr) w_status_nxt[2:0] = status_in[2:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= DATA_WIDTH'(STATUS_RST);
      r_fsr    <= '0;
      r_port_a <= '0;
      r_port_b <= '0;
      r_port_c <= '0;
      for (int unsigned i = 0; i < GPR_N; i++) r_gpr[i] <= '0;
    end else begin
      r_status <= w_status_nxt;
      if (w_cmd == WCMD_FSR) r_fsr <= write_data;
      if (w_file_wr) begin
        case (w_ea)
          ADDR_FSR:   r_fsr    <= write_data;
          ADDR_PORTA: r_port_a <= write_data;
          ADDR_PORTB: r_port_b <= write_data;
          ADDR_PORTC: r_port_c <= write_data;
          default: begin
            if (w_is_gpr) r_gpr[w_gpr_idx] <= write_data;
          end
        endcase
      end
    end
  end

  assign regfile_out = w_rd;
  assign status_out  = r_status;
  assign fsr_out     = r_fsr;
  assign tmr0_out    = w_tmr0;
  assign port_a_out  = r_port_a;
  assign port_b_out  = r_port_b;
  assign port_c_out  = r_port_c;

endmodule

// File: tb/tb_pic_banked_regfile.sv
// Scoreboard bench for pic_banked_regfile: expectations are queued as stimulus
// is applied and compared when the outputs are sampled.
module tb_pic_banked_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] write_cmd;
  logic [4:0] file_addr;
  logic [7:0] write_data, status_in;
  logic [10:0] pc_in;
  logic [3:0] option_in;
  logic [7:0] port_a_in, port_b_in, port_c_in;
  logic [7:0] port_a_out, port_b_out, port_c_out;
  logic [7:0] regfile_out, status_out, fsr_out, tmr0_out;
  logic       tmr0_ovf, pcl_wr;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int S_RD = 0, S_STATUS = 1, S_FSR = 2, S_TMR = 3, S_OVF = 4,
                 S_PCL = 5, S_PA = 6, S_PB = 7, S_PC = 8;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  pic_banked_regfile #(
    .DATA_WIDTH(8),
    .PC_WIDTH  (11),
    .NUM_BANKS (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_cmd   (write_cmd),
    .file_addr   (file_addr),
    .write_data  (write_data),
    .status_in   (status_in),
    .pc_in       (pc_in),
    .option_in   (option_in),
    .port_a_in   (port_a_in),
    .port_b_in   (port_b_in),
    .port_c_in   (port_c_in),
    .port_a_out  (port_a_out),
    .port_b_out  (port_b_out),
    .port_c_out  (port_c_out),
    .regfile_out (regfile_out),
    .status_out  (status_out),
    .fsr_out     (fsr_out),
    .tmr0_out    (tmr0_out),
    .tmr0_ovf    (tmr0_ovf),
    .pcl_wr      (pcl_wr)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_RD:     return regfile_out;
      S_STATUS: return status_out;
      S_FSR:    return fsr_out;
      S_TMR:    return tmr0_out;
      S_OVF:    return {7'd0, tmr0_ovf};
      S_PCL:    return {7'd0, pcl_wr};
      S_PA:     return port_a_out;
      S_PB:     return port_b_out;
      default:  return port_c_out;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, idle.
  task automatic wr_cmd(input logic [2:0] cmd, input logic [4:0] addr,
                        input logic [7:0] data, input logic [7:0] sin);
    write_cmd  = cmd;
    file_addr  = addr;
    write_data = data;
    status_in  = sin;
    @(negedge clk);
    write_cmd = 3'b000;
  endtask

  task automatic rd_exp(input logic [4:0] addr, input logic [7:0] exp, input string tag);
    file_addr = addr;
    expect_out(tag, S_RD, exp);
    sample();
    @(negedge clk);
  endtask

  task automatic pcl_probe(input logic [2:0] cmd, input logic [4:0] addr,
                           input logic exp, input string tag);
    write_cmd  = cmd;
    file_addr  = addr;
    write_data = 8'h00;
    expect_out(tag, S_PCL, {7'd0, exp});
    sample();
    @(negedge clk);
    write_cmd = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] tmr_exp [6] = '{8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'h00, 8'h01};
  logic       ovf_exp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rst = 1'b0;
    write_cmd = 3'b000; file_addr = 5'h00; write_data = 8'h00; status_in = 8'h00;
    pc_in = 11'h000; option_in = 4'b1000;
    port_a_in = 8'h00; port_b_in = 8'h00; port_c_in = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    expect_out("rst_status", S_STATUS, 8'h18);
    expect_out("rst_fsr", S_FSR, 8'h00);
    expect_out("rst_tmr0", S_TMR, 8'h00);
    expect_out("rst_ovf", S_OVF, 8'h00);
    expect_out("rst_porta", S_PA, 8'h00);
    sample();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      expect_out($sformatf("tmr0_free_%0d", k), S_TMR, 8'(k));
      sample();
    end
    @(negedge clk);
    for (int a = 8; a < 32; a++) rd_exp(5'(a), 8'h00, $sformatf("gpr_rst_%02h", a));

    // Banked GPRs
    wr_cmd(3'b100, 5'h1F, 8'h20, 8'h00);
    expect_out("fsr_cmd", S_FSR, 8'h20);
    sample();
    @(negedge clk);
    wr_cmd(3'b010, 5'h12, 8'hA5, 8'h00);
    wr_cmd(3'b100, 5'h00, 8'h40, 8'h00);
    wr_cmd(3'b010, 5'h12, 8'h5A, 8'h00);
    wr_cmd(3'b010, 5'h0A, 8'h33, 8'h00);
    rd_exp(5'h12, 8'h5A, "bank2_12");
    wr_cmd(3'b100, 5'h00, 8'h20, 8'h00);
    rd_exp(5'h12, 8'hA5, "bank1_12");
    rd_exp(5'h1F, 8'h00, "bank1_1f_untouched");
    rd_exp(5'h0A, 8'h33, "common_0a_b1");
    wr_cmd(3'b100, 5'h00, 8'h32, 8'h00);
    rd_exp(5'h00, 8'hA5, "indirect_bank1_12");
    wr_cmd(3'b100, 5'h00, 8'h60, 8'h00);
    rd_exp(5'h12, 8'h00, "bank3_12");
    rd_exp(5'h0A, 8'h33, "common_0a_b3");
    wr_cmd(3'b100, 5'h00, 8'h00, 8'h00);
    rd_exp(5'h12, 8'h00, "bank0_12");
    rd_exp(5'h0A, 8'h33, "common_0a_b0");

    // STATUS via INDF, INDF-via-INDF, flag commands
    wr_cmd(3'b100, 5'h00, 8'h03, 8'h00);
    wr_cmd(3'b010, 5'h00, 8'hFF, 8'h00);
    expect_out("status_indf_wr", S_STATUS, 8'hFF);
    sample();
    @(negedge clk);
    wr_cmd(3'b100, 5'h00, 8'h00, 8'h00);
    rd_exp(5'h00, 8'h00, "indf_indf_rd");
    wr_cmd(3'b010, 5'h00, 8'h77, 8'h00);
    expect_out("indf_wr_status", S_STATUS, 8'hFF);
    expect_out("indf_wr_fsr", S_FSR, 8'h00);
    sample();
    @(negedge clk);
    rd_exp(5'h0A, 8'h33, "indf_wr_gpr");
    wr_cmd(3'b001, 5'h0A, 8'hFF, 8'h00);
    expect_out("cmd001_status", S_STATUS, 8'hF8);
    sample();
    @(negedge clk);
    rd_exp(5'h0A, 8'h33, "cmd001_no_file_wr");
    wr_cmd(3'b011, 5'h03, 8'h00, 8'h05);
    expect_out("cmd011_status", S_STATUS, 8'h1D);
    sample();
    @(negedge clk);
    wr_cmd(3'b101, 5'h0B, 8'h99, 8'h07);
    wr_cmd(3'b111, 5'h04, 8'h99, 8'h07);
    expect_out("cmd1xx_status", S_STATUS, 8'h1D);
    expect_out("cmd1xx_fsr", S_FSR, 8'h00);
    sample();
    @(negedge clk);
    rd_exp(5'h0B, 8'h00, "cmd101_gpr");

    // Cmd 011 to a GPR, PCL strobe, ports
    wr_cmd(3'b010, 5'h0C, 8'h55, 8'h00);
    rd_exp(5'h0C, 8'h55, "gpr_0c_pre");
    wr_cmd(3'b011, 5'h0C, 8'h00, 8'h04);
    expect_out("cmd011_z", S_STATUS, 8'h1C);
    sample();
    @(negedge clk);
    rd_exp(5'h0C, 8'h00, "cmd011_gpr");
    status_in = 8'h04;
    pcl_probe(3'b010, 5'h02, 1'b1, "pcl_direct");
    pcl_probe(3'b010, 5'h0D, 1'b0, "pcl_other");
    pcl_probe(3'b000, 5'h02, 1'b0, "pcl_idle");
    pcl_probe(3'b110, 5'h02, 1'b0, "pcl_badcmd");
    wr_cmd(3'b100, 5'h00, 8'h02, 8'h04);
    pcl_probe(3'b011, 5'h00, 1'b1, "pcl_indirect");
    wr_cmd(3'b100, 5'h00, 8'h00, 8'h04);
    pc_in = 11'h5A3;
    rd_exp(5'h02, 8'hA3, "pcl_read");
    wr_cmd(3'b010, 5'h05, 8'h3C, 8'h04);
    wr_cmd(3'b010, 5'h06, 8'h81, 8'h04);
    wr_cmd(3'b010, 5'h07, 8'h7E, 8'h04);
    expect_out("porta_latch", S_PA, 8'h3C);
    expect_out("portb_latch", S_PB, 8'h81);
    expect_out("portc_latch", S_PC, 8'h7E);
    sample();
    @(negedge clk);
    port_a_in = 8'hC3; port_b_in = 8'h42; port_c_in = 8'h24;
    rd_exp(5'h05, 8'hC3, "porta_pins");
    rd_exp(5'h06, 8'h42, "portb_pins");
    rd_exp(5'h07, 8'h24, "portc_pins");

    // TMR0 load, inhibit and overflow pulse
    wr_cmd(3'b010, 5'h01, 8'hFE, 8'h04);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      expect_out($sformatf("tmr0_load_%0d", k), S_TMR, tmr_exp[k]);
      expect_out($sformatf("tmr0_ovf_%0d", k), S_OVF, {7'd0, ovf_exp[k]});
      sample();
    end
    @(negedge clk);

`ifdef RF_TMR0_PRESCALER_EN
    option_in = 4'b0001;
    wr_cmd(3'b010, 5'h01, 8'h00, 8'h04);
    for (int n = 0; n < 20; n++) begin
      if (n > 0) @(negedge clk);
      expect_out($sformatf("presc_%0d", n), S_TMR, (n >= 12) ? 8'((n - 8) / 4) : 8'h00);
      sample();
    end
    #2 rst = 1'b0;
    expect_out("presc_rst_tmr0", S_TMR, 8'h00);
    sample();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      expect_out($sformatf("presc_after_rst_%0d", n), S_TMR, (n >= 4) ? 8'h01 : 8'h00);
      sample();
    end
    option_in = 4'b1000;
    @(negedge clk);
`endif

    // Asynchronous reset mid-cycle
    wr_cmd(3'b100, 5'h00, 8'h40, 8'h04);
    file_addr = 5'h0A;
    #2 rst = 1'b0;
    expect_out("arst_tmr0", S_TMR, 8'h00);
    expect_out("arst_status", S_STATUS, 8'h18);
    expect_out("arst_fsr", S_FSR, 8'h00);
    expect_out("arst_porta", S_PA, 8'h00);
    expect_out("arst_gpr_0a", S_RD, 8'h00);
    sample();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
